// File: rtl/ltc2333_acq_scheduler.sv
// Round-robin scheduler sharing one LTC2333 write engine between PS software (req 0) and the trigger path (req 1).
// Optional `define ACQ_TIMEOUT_EN adds a timeout_cycles input that aborts stuck ARM/RUN phases with an err pulse.
module ltc2333_acq_scheduler #(
    parameter int NREQ          = 2,
    parameter int NCHAN         = 8,
    parameter int RESET_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*NCHAN-1:0]   req_chan_mask,
    input  logic [NREQ*16-1:0]      req_n_reads,
    input  logic [NREQ*3-1:0]       req_range,
    input  logic [NREQ*32-1:0]      req_sample_period,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         err,
    output logic                    wr_reset,
    output logic                    wr_mode,
    output logic [NCHAN-1:0]        wr_active_channels,
    output logic [15:0]             wr_n_reads,
    output logic [2:0]              wr_range,
    output logic [31:0]             wr_sample_period,
    input  logic                    wr_in_progress,
`ifdef ACQ_TIMEOUT_EN
    input  logic [31:0]             timeout_cycles,
`endif
    output logic [NREQ-1:0]         owner,
    output logic                    rr_last
);

    typedef enum logic [2:0] {IDLE, ARB, LOAD, ARM, RUN} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   req_ready_q, done_q, err_q, owner_q;
    logic              rr_last_q, wr_reset_q;
    logic [NCHAN-1:0]  wr_active_q;
    logic [15:0]       wr_n_reads_q;
    logic [2:0]        wr_range_q;
    logic [31:0]       wr_sample_q;
    logic [3:0]        rst_cnt_q, settle_cnt_q;
`ifdef ACQ_TIMEOUT_EN
    logic [31:0]       tmo_cnt_q;
`endif

    // Preferred requester is the one after the last grant; fall back to the other when it is idle.
    logic              pref, win;
    logic [NREQ-1:0]   win_oh;
    logic [NCHAN-1:0]  win_mask;
    logic [15:0]       win_reads;
    logic [2:0]        win_range;
    logic [31:0]       win_sample;

    assign pref       = ~rr_last_q;
    assign win        = req_valid[pref] ? pref : ~pref;
    assign win_oh     = {win, ~win};
    assign win_mask   = win ? req_chan_mask[2*NCHAN-1:NCHAN] : req_chan_mask[NCHAN-1:0];
    assign win_reads  = win ? req_n_reads[31:16] : req_n_reads[15:0];
    assign win_range  = win ? req_range[5:3] : req_range[2:0];
    assign win_sample = win ? req_sample_period[63:32] : req_sample_period[31:0];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            req_ready_q  <= '0;
            done_q       <= '0;
            err_q        <= '0;
            owner_q      <= '0;
            rr_last_q    <= 1'b1;
            wr_reset_q   <= 1'b1;
            wr_active_q  <= '0;
            wr_n_reads_q <= '0;
            wr_range_q   <= '0;
            wr_sample_q  <= '0;
            rst_cnt_q    <= '0;
            settle_cnt_q <= '0;
`ifdef ACQ_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            req_ready_q <= '0;
            done_q      <= '0;
            err_q       <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) state_q <= ARB;
                end
                ARB: begin
                    if (!(|req_valid)) begin
                        state_q <= IDLE;
                    end else begin
                        req_ready_q  <= win_oh;
                        rr_last_q    <= win;
                        owner_q      <= win_oh;
                        wr_active_q  <= win_mask;
                        wr_n_reads_q <= win_reads;
                        wr_range_q   <= win_range;
                        wr_sample_q  <= win_sample;
                        rst_cnt_q    <= '0;
                        settle_cnt_q <= '0;
`ifdef ACQ_TIMEOUT_EN
                        tmo_cnt_q    <= '0;
`endif
                        // Degenerate requests are answered without ever releasing the engine reset.
                        if (win_mask == '0) begin
                            err_q   <= win_oh;
                            owner_q <= '0;
                            state_q <= IDLE;
                        end else if (win_reads == 16'd0) begin
                            done_q  <= win_oh;
                            owner_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (rst_cnt_q == 4'(RESET_CYCLES - 1)) begin
                        wr_reset_q <= 1'b0;
                        state_q    <= ARM;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 4'd1;
                    end
                end
                ARM: begin
                    if (wr_in_progress) begin
                        settle_cnt_q <= '0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    // Short low glitches on in_progress restart the settle count.
                    if (wr_in_progress) begin
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q + 4'd1 == 4'(SETTLE_CYCLES)) begin
                        done_q     <= owner_q;
                        wr_reset_q <= 1'b1;
                        owner_q    <= '0;
                        state_q    <= IDLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef ACQ_TIMEOUT_EN
            if (state_q == ARM || state_q == RUN) begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
                if (timeout_cycles != 32'd0 && tmo_cnt_q + 32'd1 == timeout_cycles) begin
                    err_q      <= owner_q;
                    done_q     <= '0;
                    wr_reset_q <= 1'b1;
                    owner_q    <= '0;
                    state_q    <= IDLE;
                end
            end
`endif
        end
    end

    assign req_ready          = req_ready_q;
    assign done               = done_q;
    assign err                = err_q;
    assign owner              = owner_q;
    assign rr_last            = rr_last_q;
    assign wr_reset           = wr_reset_q;
    assign wr_mode            = 1'b0;
    assign wr_active_channels = wr_active_q;
    assign wr_n_reads         = wr_n_reads_q;
    assign wr_range           = wr_range_q;
    assign wr_sample_period   = wr_sample_q;

endmodule

// File: tb/tb_ltc2333_acq_scheduler.sv
// Directed bench for ltc2333_acq_scheduler: expected ready/done/err events are queued when a request is driven
// and compared when the scheduler emits them; optional ACQ_TIMEOUT_EN section exercises the timeout abort.
module tb_ltc2333_acq_scheduler;

    typedef struct packed {
        logic [1:0] ready;
        logic [1:0] dn;
        logic [1:0] er;
    } ev_t;

    logic        clk;
    logic        aresetn;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [15:0] reqChanMask;
    logic [31:0] reqNReads;
    logic [5:0]  reqRange;
    logic [63:0] reqSamplePeriod;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        wrReset;
    logic        wrMode;
    logic [7:0]  wrActive;
    logic [15:0] wrNReads;
    logic [2:0]  wrRange;
    logic [31:0] wrSample;
    logic        wrInProgress;
    logic [1:0]  owner;
    logic        rrLast;
`ifdef ACQ_TIMEOUT_EN
    logic [31:0] timeoutCycles;
`endif

    int  checkCount;
    int  errorCount;
    ev_t expQ[$];

    ltc2333_acq_scheduler dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .req_valid          (reqValid),
        .req_ready          (reqReady),
        .req_chan_mask      (reqChanMask),
        .req_n_reads        (reqNReads),
        .req_range          (reqRange),
        .req_sample_period  (reqSamplePeriod),
        .done               (done),
        .err                (err),
        .wr_reset           (wrReset),
        .wr_mode            (wrMode),
        .wr_active_channels (wrActive),
        .wr_n_reads         (wrNReads),
        .wr_range           (wrRange),
        .wr_sample_period   (wrSample),
        .wr_in_progress     (wrInProgress),
`ifdef ACQ_TIMEOUT_EN
        .timeout_cycles     (timeoutCycles),
`endif
        .owner              (owner),
        .rr_last            (rrLast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ev_t mkEv(input logic [1:0] r, input logic [1:0] d, input logic [1:0] e);
        return {r, d, e};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] mask, input logic [15:0] reads,
                                 input logic [2:0] rng, input logic [31:0] per);
        reqChanMask[idx*8 +: 8]      = mask;
        reqNReads[idx*16 +: 16]      = reads;
        reqRange[idx*3 +: 3]         = rng;
        reqSamplePeriod[idx*32 +: 32] = per;
    endtask

    // Waits for the next nonzero ready/done/err vector and compares it with the oldest queued expectation.
    task automatic waitEvent(input string tag, input int budget, output int cycles);
        ev_t exp;
        ev_t obs;
        bool_loop: begin end
        exp    = expQ.pop_front();
        obs    = '0;
        cycles = 0;
        while (cycles < budget && obs == '0) begin
            @(negedge clk);
            cycles++;
            obs = {reqReady, done, err};
        end
        checkOutput(tag, 64'(obs), 64'(exp));
    endtask

    task automatic waitResetLow(output int cycles);
        cycles = 0;
        while (wrReset !== 1'b0 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int lowCyc;
        logic [1:0] oh;

        checkCount      = 0;
        errorCount      = 0;
        aresetn         = 1'b0;
        reqValid        = '0;
        reqChanMask     = '0;
        reqNReads       = '0;
        reqRange        = '0;
        reqSamplePeriod = '0;
        wrInProgress    = 1'b0;
`ifdef ACQ_TIMEOUT_EN
        timeoutCycles   = '0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_reset", 64'(wrReset), 64'd1);
        checkOutput("rst_rr_last", 64'(rrLast), 64'd1);
        checkOutput("rst_owner", 64'(owner), 64'd0);
        checkOutput("rst_events", 64'({reqReady, done, err}), 64'd0);
        checkOutput("rst_cfg", 64'({wrMode, wrActive, wrNReads, wrRange}), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);

        // Single request from software.
        applyStimulus(0, 8'h05, 16'd3, 3'd5, 32'd100);
        reqValid = 2'b01;
        expQ.push_back(mkEv(2'b01, 2'b00, 2'b00));
        waitEvent("single_ready", 10, cyc);
        checkOutput("single_grant_lat", 64'(cyc), 64'd2);
        reqValid = 2'b00;
        applyStimulus(0, 8'hAA, 16'd9, 3'd1, 32'd7);
        checkOutput("single_cfg", 64'({wrActive, wrNReads, wrRange, wrSample}),
                    64'({8'h05, 16'd3, 3'd5, 32'd100}));
        checkOutput("single_owner", 64'(owner), 64'd1);
        checkOutput("single_rr_last", 64'(rrLast), 64'd0);
        waitResetLow(lowCyc);
        checkOutput("single_reset_len", 64'(lowCyc), 64'd4);
        checkOutput("single_cfg_stable", 64'(wrActive), 64'h05);
        wrInProgress = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("single_busy_done", 64'(done), 64'd0);
        checkOutput("single_owner_run", 64'(owner), 64'd1);
        wrInProgress = 1'b0;
        expQ.push_back(mkEv(2'b00, 2'b01, 2'b00));
        waitEvent("single_done", 10, cyc);
        checkOutput("single_done_lat", 64'(cyc), 64'd2);
        checkOutput("single_reset_back", 64'(wrReset), 64'd1);
        checkOutput("single_owner_clr", 64'(owner), 64'd0);

        // Zero channel mask on the trigger path is rejected.
        applyStimulus(1, 8'h00, 16'd5, 3'd2, 32'd50);
        reqValid = 2'b10;
        expQ.push_back(mkEv(2'b10, 2'b00, 2'b10));
        waitEvent("zmask_err", 10, cyc);
        checkOutput("zmask_lat", 64'(cyc), 64'd2);
        reqValid = 2'b00;
        checkOutput("zmask_rr_last", 64'(rrLast), 64'd1);
        checkOutput("zmask_owner", 64'(owner), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("zmask_reset_held", 64'(wrReset), 64'd1);
        checkOutput("zmask_quiet", 64'({reqReady, done, err}), 64'd0);

        // Contention: both requesters held valid, grants must alternate starting with 0.
        applyStimulus(0, 8'h01, 16'd1, 3'd0, 32'd10);
        applyStimulus(1, 8'h02, 16'd1, 3'd0, 32'd10);
        reqValid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            oh = (g % 2 == 0) ? 2'b01 : 2'b10;
            expQ.push_back(mkEv(oh, 2'b00, 2'b00));
            waitEvent($sformatf("cont_ready%0d", g), 10, cyc);
            checkOutput($sformatf("cont_lat%0d", g), 64'(cyc), 64'd2);
            checkOutput($sformatf("cont_owner%0d", g), 64'(owner), 64'(oh));
            checkOutput($sformatf("cont_rr%0d", g), 64'(rrLast), 64'(g % 2));
            checkOutput($sformatf("cont_mask%0d", g), 64'(wrActive), 64'(oh));
            waitResetLow(lowCyc);
            wrInProgress = 1'b1;
            @(negedge clk);
            wrInProgress = 1'b0;
            expQ.push_back(mkEv(2'b00, oh, 2'b00));
            waitEvent($sformatf("cont_done%0d", g), 10, cyc);
            checkOutput($sformatf("cont_done_lat%0d", g), 64'(cyc), 64'd2);
            if (g == 3) reqValid = 2'b00;
        end

        // Zero conversion count completes without touching the engine.
        applyStimulus(0, 8'hFF, 16'd0, 3'd7, 32'd20);
        reqValid = 2'b01;
        expQ.push_back(mkEv(2'b01, 2'b01, 2'b00));
        waitEvent("zreads_done", 10, cyc);
        checkOutput("zreads_lat", 64'(cyc), 64'd2);
        reqValid = 2'b00;
        @(negedge clk);
        checkOutput("zreads_reset_held", 64'(wrReset), 64'd1);
        checkOutput("zreads_owner", 64'(owner), 64'd0);

        // A single-cycle low on in_progress must not complete the run.
        applyStimulus(1, 8'h81, 16'd7, 3'd3, 32'd40);
        reqValid = 2'b10;
        expQ.push_back(mkEv(2'b10, 2'b00, 2'b00));
        waitEvent("glitch_ready", 10, cyc);
        reqValid = 2'b00;
        waitResetLow(lowCyc);
        wrInProgress = 1'b1;
        repeat (2) @(negedge clk);
        wrInProgress = 1'b0;
        @(negedge clk);
        wrInProgress = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("glitch_no_done", 64'(done), 64'd0);
        checkOutput("glitch_owner", 64'(owner), 64'd2);
        wrInProgress = 1'b0;
        expQ.push_back(mkEv(2'b00, 2'b10, 2'b00));
        waitEvent("glitch_done", 10, cyc);
        checkOutput("glitch_done_lat", 64'(cyc), 64'd2);

        // Asynchronous reset in the middle of a run.
        applyStimulus(0, 8'h03, 16'd2, 3'd4, 32'd30);
        reqValid = 2'b01;
        expQ.push_back(mkEv(2'b01, 2'b00, 2'b00));
        waitEvent("abort_ready", 10, cyc);
        reqValid = 2'b00;
        waitResetLow(lowCyc);
        wrInProgress = 1'b1;
        repeat (2) @(negedge clk);
        aresetn = 1'b0;
        #1;
        checkOutput("abort_wr_reset", 64'(wrReset), 64'd1);
        checkOutput("abort_owner", 64'(owner), 64'd0);
        wrInProgress = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort_quiet", 64'({reqReady, done, err}), 64'd0);
        checkOutput("abort_rr_last", 64'(rrLast), 64'd1);

`ifdef ACQ_TIMEOUT_EN
        // Engine stuck busy: timeout fires after 100 cycles of ARM+RUN.
        timeoutCycles = 32'd100;
        applyStimulus(0, 8'h01, 16'd5, 3'd0, 32'd10);
        reqValid = 2'b01;
        expQ.push_back(mkEv(2'b01, 2'b00, 2'b00));
        waitEvent("tmo_ready", 10, cyc);
        reqValid = 2'b00;
        wrInProgress = 1'b1;
        expQ.push_back(mkEv(2'b00, 2'b00, 2'b01));
        waitEvent("tmo_err", 200, cyc);
        checkOutput("tmo_lat", 64'(cyc), 64'd104);
        checkOutput("tmo_wr_reset", 64'(wrReset), 64'd1);
        checkOutput("tmo_owner", 64'(owner), 64'd0);
        wrInProgress = 1'b0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
